// File: rtl/fetch_queue_stage_pkg.sv
// rtl/fetch_queue_stage_pkg.sv - shared widths, entry type and PC helper for the fetch stage
package fetch_queue_stage_pkg;

  localparam int PC_WIDTH = 32;
  localparam int IWIDTH   = 32;
  localparam int PC_STEP  = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;
  typedef logic [IWIDTH-1:0]   instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fq_entry_t;

  function automatic pc_t next_pc(input pc_t pc);
    return pc + pc_t'(PC_STEP);
  endfunction

endpackage

// File: rtl/fetch_queue_stage_if.sv
// rtl/fetch_queue_stage_if.sv - redirect, instruction-memory and decode-slot signals of the fetch stage
interface fetch_queue_stage_if;
  import fetch_queue_stage_pkg::*;

  logic   fs_i_change_pc;
  pc_t    fs_i_alu_pc;
  logic   fs_i_fetch_queue;
  logic   fs_o_imem_req;
  pc_t    fs_o_imem_addr;
  logic   fs_i_imem_valid;
  instr_t fs_i_imem_data;
  logic   fs_i_stall;
  logic   fs_o_ce0;
  logic   fs_o_ce1;
  instr_t fs_o_instr0;
  instr_t fs_o_instr1;
  pc_t    fs_o_pc0;
  pc_t    fs_o_pc1;

  modport master (
    input  fs_i_change_pc, fs_i_alu_pc, fs_i_fetch_queue,
    input  fs_i_imem_valid, fs_i_imem_data, fs_i_stall,
    output fs_o_imem_req, fs_o_imem_addr,
    output fs_o_ce0, fs_o_ce1, fs_o_instr0, fs_o_instr1, fs_o_pc0, fs_o_pc1
  );

  modport slave (
    output fs_i_change_pc, fs_i_alu_pc, fs_i_fetch_queue,
    output fs_i_imem_valid, fs_i_imem_data, fs_i_stall,
    input  fs_o_imem_req, fs_o_imem_addr,
    input  fs_o_ce0, fs_o_ce1, fs_o_instr0, fs_o_instr1, fs_o_pc0, fs_o_pc1
  );

endinterface

// File: rtl/fetch_queue_stage_fifo.sv
// rtl/fetch_queue_stage_fifo.sv - circular {pc, instr} buffer, one push and up to two pops per cycle
module fetch_fifo
  import fetch_queue_stage_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  fq_entry_t     push_entry,
  input  logic [1:0]    pop_cnt,
  output logic [CW-1:0] count,
  output fq_entry_t     head0,
  output fq_entry_t     head1
);

  fq_entry_t     mem_q [DEPTH];
  fq_entry_t     mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // The caller never pops more than count, nor pushes into a full buffer.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_entry;
        tail_d        = tail_q + AW'(1);
      end
      head_d  = head_q + AW'(pop_cnt);
      count_d = count_q + CW'(push) - CW'(pop_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    count = count_q;
    head0 = mem_q[head_q];
    head1 = mem_q[head_q + AW'(1)];
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - fetch PC, single-outstanding imem requests and dual-slot instruction queue
// Optional FETCH_PERF_CNT_EN adds saturating redirect and stall counters.
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter int  QDEPTH   = 8,
  parameter pc_t RESET_PC = '0
) (
  input  logic                 fs_i_clk,
  input  logic                 fs_i_rst,
  fetch_queue_stage_if.master  fs
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          fs_o_redirect_cnt,
  output logic [31:0]          fs_o_stall_cnt
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  pc_t           pc_q, pc_d;
  pc_t           req_addr_q, req_addr_d;
  logic          out_q, out_d;
  logic          drop_q, drop_d;
  logic          redirect;
  logic          req;
  logic          push;
  logic [1:0]    pop_cnt;
  fq_entry_t     push_entry;
  logic [CW-1:0] count;
  fq_entry_t     head0, head1;
  logic          ce0, ce1;

  fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk        (fs_i_clk),
    .rst        (fs_i_rst),
    .clear      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop_cnt    (pop_cnt),
    .count      (count),
    .head0      (head0),
    .head1      (head1)
  );

  // A response arriving this cycle frees the outstanding slot, so a new request may go out alongside it.
  always_comb begin
    redirect = fs.fs_i_change_pc | fs.fs_i_fetch_queue;
    req      = !fs_i_rst && (!out_q || fs.fs_i_imem_valid)
               && ((count + CW'(out_q)) < CW'(QDEPTH)) && !redirect;
    push     = fs.fs_i_imem_valid && out_q && !drop_q && !redirect;
    if (redirect || fs.fs_i_stall) pop_cnt = 2'd0;
    else if (count >= CW'(2))      pop_cnt = 2'd2;
    else                           pop_cnt = {1'b0, count[0]};
    push_entry.pc    = req_addr_q;
    push_entry.instr = fs.fs_i_imem_data;

    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    out_d      = out_q;
    drop_d     = drop_q;
    if (fs.fs_i_change_pc) begin
      pc_d = fs.fs_i_alu_pc;
    end else if (fs.fs_i_fetch_queue) begin
      if (count != '0) pc_d = head0.pc;
      else if (out_q)  pc_d = req_addr_q;
    end else if (req) begin
      pc_d = next_pc(pc_q);
    end
    // Only a response still in flight after the redirect needs dropping later.
    if (redirect && out_q && !fs.fs_i_imem_valid) drop_d = 1'b1;
    if (fs.fs_i_imem_valid && out_q) begin
      out_d  = 1'b0;
      drop_d = 1'b0;
    end
    if (req) begin
      out_d      = 1'b1;
      req_addr_d = pc_q;
    end
  end

  always_ff @(posedge fs_i_clk or posedge fs_i_rst) begin
    if (fs_i_rst) begin
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      out_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    ce0               = !fs_i_rst && !redirect && (count != '0);
    ce1               = !fs_i_rst && !redirect && (count >= CW'(2));
    fs.fs_o_imem_req  = req;
    fs.fs_o_imem_addr = fs_i_rst ? '0 : pc_q;
    fs.fs_o_ce0       = ce0;
    fs.fs_o_ce1       = ce1;
    fs.fs_o_pc0       = ce0 ? head0.pc    : '0;
    fs.fs_o_instr0    = ce0 ? head0.instr : '0;
    fs.fs_o_pc1       = ce1 ? head1.pc    : '0;
    fs.fs_o_instr1    = ce1 ? head1.instr : '0;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (redirect && (redirect_cnt_q != '1))
      redirect_cnt_d = redirect_cnt_q + 32'd1;
    if (fs.fs_i_stall && (count != '0) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge fs_i_clk or posedge fs_i_rst) begin
    if (fs_i_rst) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign fs_o_redirect_cnt = redirect_cnt_q;
  assign fs_o_stall_cnt    = stall_cnt_q;
`endif

endmodule
